// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Video timing generator and pixel-output stage for the HDMI/VGA
//            path. It generates hsync/vsync/data-enable from a free-running
//            pixel/line counter pair. During active pixels it pops one word
//            from a show-ahead pixel FIFO. It can substitute a 32x32
//            checkerboard test pattern, and it raises a sticky flag when the
//            FIFO runs dry during active video.
// Ports    :
//   pixel_clk     in   pixel clock (only clock)
//   pixel_rst     in   asynchronous active-high reset
//   pattern_sel   in   1 = checkerboard, 0 = FIFO data
//   fifo_data     in   [23:0] FIFO head word {R,G,B}
//   fifo_empty    in   FIFO empty
//   fifo_rd       out  pop FIFO head (combinational)
//   clr_underflow in   synchronous clear of underflow flag
//   vga_hs/vs     out  active-low syncs (registered)
//   vga_de        out  data enable (registered)
//   vga_rgb       out  [23:0] pixel colour (registered)
//   pix_x/pix_y   out  [10:0] coordinate of the pixel on vga_rgb
//   frame_start   out  one-cycle pulse alongside pixel (0,0)
//   underflow     out  sticky FIFO underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        pattern_sel,
  input  logic [23:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic        clr_underflow,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;

  localparam logic [10:0] C_H_DISP   = 11'(HDISP);
  localparam logic [10:0] C_H_SYNC_S = 11'(HDISP + HFP);
  localparam logic [10:0] C_H_SYNC_E = 11'(HDISP + HFP + HPULSE);
  localparam logic [10:0] C_H_LAST   = 11'(HTOT - 1);
  localparam logic [10:0] C_V_DISP   = 11'(VDISP);
  localparam logic [10:0] C_V_SYNC_S = 11'(VDISP + VFP);
  localparam logic [10:0] C_V_SYNC_E = 11'(VDISP + VFP + VPULSE);
  localparam logic [10:0] C_V_LAST   = 11'(VTOT - 1);

  // Counter state
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;

  // Output-stage state
  logic        hs_q, vs_q, de_q, fs_q, uf_q;
  logic [23:0] rgb_q;
  logic [10:0] x_q, y_q;

  // Next-state values for the output stage
  logic        hs_d, vs_d, de_d, fs_d, uf_d;
  logic [23:0] rgb_d;

  logic        w_active;
  logic        w_uf_set;

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == C_H_LAST) begin
      hcnt_d = 11'd0;
      vcnt_d = (vcnt_q == C_V_LAST) ? 11'd0 : vcnt_q + 11'd1;
    end
  end

  always_comb begin
    w_active = (hcnt_q < C_H_DISP) && (vcnt_q < C_V_DISP);
    // Underflow only counts when the FIFO is actually the pixel source.
    w_uf_set = w_active && !pattern_sel && fifo_empty;
    // Gated with reset so no pop can leak out while the timing is held.
    fifo_rd  = w_active && !pattern_sel && !fifo_empty && !pixel_rst;

    hs_d = !((hcnt_q >= C_H_SYNC_S) && (hcnt_q < C_H_SYNC_E));
    vs_d = !((vcnt_q >= C_V_SYNC_S) && (vcnt_q < C_V_SYNC_E));
    de_d = w_active;
    fs_d = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);

    rgb_d = 24'h000000;
    if (w_active) begin
      if (pattern_sel) begin
        rgb_d = (hcnt_q[5] ^ vcnt_q[5]) ? 24'hFFFFFF : 24'h000000;
      end else if (!fifo_empty) begin
        rgb_d = fifo_data;
      end
    end

    // A fresh underflow takes priority over a clear on the same cycle.
    uf_d = uf_q;
    if (w_uf_set) begin
      uf_d = 1'b1;
    end else if (clr_underflow) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt_q <= 11'd0;
      vcnt_q <= 11'd0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      rgb_q  <= 24'h000000;
      x_q    <= 11'd0;
      y_q    <= 11'd0;
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      rgb_q  <= rgb_d;
      x_q    <= hcnt_q;
      y_q    <= vcnt_q;
      fs_q   <= fs_d;
      uf_q   <= uf_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. It uses a reduced-size
//            timing so that several whole frames fit in a short run. A
//            behavioural model derives every pixel's expected outputs from
//            its linear index since reset (x = n mod HTOT,
//            y = (n div HTOT) mod VTOT). The bench's FIFO is an
//            incrementing word source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HDISP  = 80;
  localparam int HFP    = 4;
  localparam int HPULSE = 6;
  localparam int HBP    = 5;
  localparam int VDISP  = 40;
  localparam int VFP    = 3;
  localparam int VPULSE = 2;
  localparam int VBP    = 4;
  localparam int HTOT   = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT   = VDISP + VFP + VPULSE + VBP;
  localparam int FRAME  = HTOT * VTOT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst;
  logic        pattern_sel;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        clr_underflow;
  logic        vga_hs, vga_vs, vga_de, frame_start, underflow;
  logic [23:0] vga_rgb;
  logic [10:0] pix_x, pix_y;

  vga_timing_gen #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) u_dut (
    .pixel_clk    (pixel_clk),
    .pixel_rst    (pixel_rst),
    .pattern_sel  (pattern_sel),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .clr_underflow(clr_underflow),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_de       (vga_de),
    .vga_rgb      (vga_rgb),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_start  (frame_start),
    .underflow    (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          pix_n;      // pixel index since reset release
  logic        uf_m;       // model of the sticky underflow flag
  logic [23:0] word;       // current FIFO head in the model FIFO
  int          pops;
  int          fs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pixel index %0d, t=%0t)", tag, got, exp, pix_n, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_hs",  32'(vga_hs), 32'd1);
    check("rst_vs",  32'(vga_vs), 32'd1);
    check("rst_de",  32'(vga_de), 32'd0);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_x",   32'(pix_x), 32'd0);
    check("rst_y",   32'(pix_y), 32'd0);
    check("rst_fs",  32'(frame_start), 32'd0);
    check("rst_uf",  32'(underflow), 32'd0);
    check("rst_rd",  32'(fifo_rd), 32'd0);
  endtask

  // One pixel: drive inputs after the falling edge, check the pop request,
  // clock it in, then check the registered outputs against the model.
  task automatic step(input logic pat, input logic emp, input logic clr);
    int          x, y;
    logic        act, rd, hs, vs, fs;
    logic [23:0] rgb;
    pattern_sel   = pat;
    fifo_empty    = emp;
    clr_underflow = clr;
    fifo_data     = emp ? 24'($urandom) : word;

    x   = pix_n % HTOT;
    y   = (pix_n / HTOT) % VTOT;
    act = (x < HDISP) && (y < VDISP);
    rd  = act && !pat && !emp;
    hs  = !((x >= HDISP + HFP) && (x < HDISP + HFP + HPULSE));
    vs  = !((y >= VDISP + VFP) && (y < VDISP + VFP + VPULSE));
    fs  = (pix_n % FRAME) == 0;
    if (!act)      rgb = 24'h000000;
    else if (pat)  rgb = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
    else if (!emp) rgb = word;
    else           rgb = 24'h000000;

    #1;
    check("fifo_rd", 32'(fifo_rd), 32'(rd));
    @(posedge pixel_clk);
    #1;
    if (act && !pat && emp) uf_m = 1'b1;
    else if (clr)           uf_m = 1'b0;

    check("vga_hs",      32'(vga_hs), 32'(hs));
    check("vga_vs",      32'(vga_vs), 32'(vs));
    check("vga_de",      32'(vga_de), 32'(act));
    check("vga_rgb",     32'(vga_rgb), 32'(rgb));
    check("pix_x",       32'(pix_x), 32'(x));
    check("pix_y",       32'(pix_y), 32'(y));
    check("frame_start", 32'(frame_start), 32'(fs));
    check("underflow",   32'(underflow), 32'(uf_m));

    if (frame_start) fs_seen++;
    if (rd) begin
      word = word + 24'd1;
      pops++;
    end
    pix_n++;
    @(negedge pixel_clk);
  endtask

  task automatic release_reset();
    pixel_rst = 1'b0;
    pix_n     = 0;
    uf_m      = 1'b0;
  endtask

  initial begin
    pixel_rst     = 1'b1;
    pattern_sel   = 1'b0;
    fifo_empty    = 1'b0;
    clr_underflow = 1'b0;
    fifo_data     = 24'h123456;
    word          = 24'h000001;
    pops          = 0;
    fs_seen       = 0;
    pix_n         = 0;
    uf_m          = 1'b0;

    // Reset values are held across clock edges; fifo_rd stays low even
    // though the counters sit on an active pixel with a non-empty FIFO.
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_vals();

    // Test pattern for a whole frame plus a margin: the second frame_start
    // must land exactly one frame period after the first.
    release_reset();
    for (int i = 0; i < FRAME + 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("fs_count_pattern", 32'(fs_seen), 32'd2);

    // Clean FIFO stream over one full frame: one pop per active pixel.
    pops = 0;
    while ((pix_n % FRAME) != 0) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b0, 1'b0);
    check("pops_per_frame", 32'(pops), 32'(HDISP * VDISP));
    check("no_underflow",   32'(underflow), 32'd0);

    // Randomized mix of source select, empty and clear.
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    // Directed underflow at pixel (50,10), then hold, clear, and a
    // coincident set/clear.
    step(1'b0, 1'b0, 1'b1);
    while (!(((pix_n % HTOT) == 50) && (((pix_n / HTOT) % VTOT) == 10))) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    check("uf_sticky", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("uf_cleared", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("uf_set_wins", 32'(underflow), 32'd1);

    // Mid-line reset: the outputs must go to reset values immediately.
    while ((pix_n % HTOT) != 30) step(1'b0, 1'b0, 1'b0);
    pattern_sel   = 1'b0;
    fifo_empty    = 1'b0;
    clr_underflow = 1'b0;
    pixel_rst     = 1'b1;
    #1;
    check_reset_vals();
    @(posedge pixel_clk);
    #1;
    check_reset_vals();
    @(negedge pixel_clk);
    release_reset();
    fs_seen = 0;
    for (int i = 0; i < 3 * HTOT; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), 1'b0);
    end
    check("fs_after_rst", 32'(fs_seen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
